// File: rtl/coasia_pkg.sv
// coasia_pkg: shared encodings for the approval scheduler and its engine interface.
package coasia_pkg;
    localparam int LANG_W = 3;
    typedef enum logic [1:0] {UNKNOWN = 2'd0, ACCEPT = 2'd1, REJECT = 2'd2} approval_e;
    typedef enum logic [LANG_W-1:0] {NONE = 3'd0} lang_cer_e;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} sched_state_e;
endpackage

// File: rtl/coasia_rr_arbiter.sv
// coasia_rr_arbiter: combinational round-robin pick, first valid requester at/after ptr.
module coasia_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);
    int j;
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (req[j] && !any) begin
                any = 1'b1;
                idx = IDX_W'(j);
            end
        end
        gnt[idx] = any;
    end
endmodule

// File: rtl/coasia_approval_sched.sv
// coasia_approval_sched: round-robin sharing of one approval engine among NUM_REQ applicants
// with per-requester handshakes and saturating accept/reject statistics.
module coasia_approval_sched
    import coasia_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W = 16,
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_kore_sub,
    input  logic [NUM_REQ*LANG_W-1:0] req_lang_cer,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [1:0]                resp_approval,
    output logic                      app_kore_sub,
    output logic [LANG_W-1:0]         app_lang_cer,
    input  logic [1:0]                app_approval,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_idx,
    output logic [CNT_W-1:0]          accept_cnt,
    output logic [CNT_W-1:0]          reject_cnt
);
    sched_state_e state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win_idx;
    logic [NUM_REQ-1:0] win_gnt;
    logic win_any;

    coasia_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req(req_valid),
        .ptr(ptr),
        .gnt(win_gnt),
        .idx(win_idx),
        .any(win_any)
    );

    assign req_ready = (state == IDLE) ? win_gnt : '0;
    assign busy = state != IDLE;

    always_comb begin
        resp_valid = '0;
        resp_valid[grant_idx] = state == RESP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr <= '0;
            grant_idx <= '0;
            resp_approval <= UNKNOWN;
            app_kore_sub <= 1'b0;
            app_lang_cer <= NONE;
            accept_cnt <= '0;
            reject_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (win_any) begin
                    app_kore_sub <= req_kore_sub[win_idx];
                    app_lang_cer <= req_lang_cer[win_idx*LANG_W +: LANG_W];
                    grant_idx <= win_idx;
                    ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    state <= ISSUE;
                end
                ISSUE: state <= CAPTURE;
                CAPTURE: begin
                    resp_approval <= app_approval;
                    app_kore_sub <= 1'b0;
                    app_lang_cer <= NONE;
                    state <= RESP;
                end
                RESP: if (resp_ready[grant_idx]) begin
                    // UNKNOWN decisions are delivered but counted nowhere
                    if (resp_approval == ACCEPT && !(&accept_cnt)) accept_cnt <= accept_cnt + 1'b1;
                    if (resp_approval == REJECT && !(&reject_cnt)) reject_cnt <= reject_cnt + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
